// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode/execute boundary.
// The control bundle width is derived from ctrl_t.
package pipe_pkg;

   localparam int LOAD_STALL_MIN = 1;
   localparam int LOAD_STALL_MAX = 3;
   localparam int REG_AW_DEF     = 5;

   typedef logic [REG_AW_DEF-1:0] reg_addr_t;

   typedef struct packed {
      logic [4:0] alu_control;
      logic       alu_src;
      logic       branch;
      logic       jump;
      logic       jump_reg;
      logic       link;
      logic [2:0] load_type;
      logic [1:0] store_type;
      logic [2:0] branch_type;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       shift_src;
      logic       rsvd;
   } ctrl_t;

   localparam int CTRL_BITS = $bits(ctrl_t);

   function automatic bit ls_legal(int n);
      return (n >= LOAD_STALL_MIN) && (n <= LOAD_STALL_MAX);
   endfunction

endpackage

// File: rtl/decode_issue_reg_if.sv
// Decode-side bundle in, execute-side bundle out, plus stall/perf.
// master = decode/control side, slave = the issue register.
interface decode_issue_reg_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CTRL_W = 24,
   parameter int PERF_W = 16
);
   logic              in_valid;
   logic [REG_AW-1:0] in_rs, in_rt, in_rd, in_dst;
   logic              in_uses_rs, in_uses_rt, in_is_load;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_imm, in_pc_next;
   logic [4:0]        in_shamt;
   logic              flush, ext_stall;

   logic              out_valid;
   logic [REG_AW-1:0] out_rs, out_rt, out_rd, out_dst;
   logic              out_uses_rs, out_uses_rt, out_is_load;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_imm, out_pc_next;
   logic [4:0]        out_shamt;
   logic              stall_req;
   logic [PERF_W-1:0] bubble_cnt;

   modport master (
      output in_valid, in_rs, in_rt, in_rd, in_dst,
             in_uses_rs, in_uses_rt, in_is_load,
             in_ctrl, in_imm, in_pc_next, in_shamt,
             flush, ext_stall,
      input  out_valid, out_rs, out_rt, out_rd, out_dst,
             out_uses_rs, out_uses_rt, out_is_load,
             out_ctrl, out_imm, out_pc_next, out_shamt,
             stall_req, bubble_cnt
   );

   modport slave (
      input  in_valid, in_rs, in_rt, in_rd, in_dst,
             in_uses_rs, in_uses_rt, in_is_load,
             in_ctrl, in_imm, in_pc_next, in_shamt,
             flush, ext_stall,
      output out_valid, out_rs, out_rt, out_rd, out_dst,
             out_uses_rs, out_uses_rt, out_is_load,
             out_ctrl, out_imm, out_pc_next, out_shamt,
             stall_req, bubble_cnt
   );
endinterface

// File: rtl/load_scoreboard.sv
// Tracks in-flight loads over LOAD_STALL slots; entry 0 is the EX register.
// Flags a hazard when a valid decode source hits a pending load destination.
module load_scoreboard #(
   parameter int LOAD_STALL = 1,
   parameter int REG_AW     = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_shift,
   input  logic              i_hold,
   input  logic              i_clear_tail,
   input  logic              i_head_v,
   input  logic [REG_AW-1:0] i_head_addr,
   input  logic              i_valid,
   input  logic [REG_AW-1:0] i_rs,
   input  logic [REG_AW-1:0] i_rt,
   input  logic              i_uses_rs,
   input  logic              i_uses_rt,
   output logic              o_hazard
);
   logic              w_v    [LOAD_STALL];
   logic [REG_AW-1:0] w_addr [LOAD_STALL];

   assign w_v[0]    = i_head_v;
   assign w_addr[0] = i_head_addr;

   if (LOAD_STALL > 1) begin : g_tail
      logic              r_v    [1:LOAD_STALL-1];
      logic [REG_AW-1:0] r_addr [1:LOAD_STALL-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 1; k < LOAD_STALL; k++) begin
               r_v[k]    <= 1'b0;
               r_addr[k] <= '0;
            end
         end else if (i_clear_tail) begin
            for (int k = 1; k < LOAD_STALL; k++)
               r_v[k] <= 1'b0;
         end else if (i_shift && !i_hold) begin
            for (int k = 1; k < LOAD_STALL; k++) begin
               r_v[k]    <= w_v[k-1];
               r_addr[k] <= w_addr[k-1];
            end
         end
      end

      for (genvar k = 1; k < LOAD_STALL; k++) begin : g_map
         assign w_v[k]    = r_v[k];
         assign w_addr[k] = r_addr[k];
      end
   end else begin : g_head_only
      logic w_unused;
      assign w_unused = ^{clk, rst_n, i_shift, i_hold, i_clear_tail};
   end

   // r0 is hardwired, so a pending "load to r0" never blocks anyone
   always_comb begin
      o_hazard = 1'b0;
      for (int k = 0; k < LOAD_STALL; k++) begin
         if (w_v[k] && (w_addr[k] != '0)) begin
            if ((i_uses_rs && (i_rs == w_addr[k])) ||
                (i_uses_rt && (i_rt == w_addr[k])))
               o_hazard = 1'b1;
         end
      end
      o_hazard = o_hazard & i_valid;
   end

endmodule

// File: rtl/decode_issue_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion.
// Edge priority: flush, downstream hold, hazard bubble, normal issue.
module decode_issue_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int CTRL_W     = CTRL_BITS,
   parameter int LOAD_STALL = 1,
   parameter int PERF_W     = 16
) (
   input logic               clk,
   input logic               rst_n,
   decode_issue_reg_if.slave bus
);
   if (!ls_legal(LOAD_STALL)) begin : g_bad_ls
      $error("decode_issue_reg: LOAD_STALL out of range");
   end

   logic              r_valid;
   logic [REG_AW-1:0] r_rs, r_rt, r_rd, r_dst;
   logic              r_uses_rs, r_uses_rt, r_is_load;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_imm, r_pc_next;
   logic [4:0]        r_shamt;
   logic [PERF_W-1:0] r_cnt;

   logic w_hazard, w_adv, w_take, w_bump, w_head_v, w_hold;

   // a flush overrides a downstream hold, so the register still advances
   assign w_adv    = bus.flush | ~bus.ext_stall;
   assign w_hold   = bus.ext_stall & ~bus.flush;
   assign w_take   = ~bus.flush & ~w_hazard & bus.in_valid;
   assign w_bump   = ~bus.flush & ~bus.ext_stall & w_hazard & ~(&r_cnt);
   assign w_head_v = r_valid & r_is_load & (r_dst != '0);

   load_scoreboard #(
      .LOAD_STALL (LOAD_STALL),
      .REG_AW     (REG_AW)
   ) u_sb (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_shift      (w_adv),
      .i_hold       (w_hold),
      .i_clear_tail (1'b0),
      .i_head_v     (w_head_v),
      .i_head_addr  (r_dst),
      .i_valid      (bus.in_valid),
      .i_rs         (bus.in_rs),
      .i_rt         (bus.in_rt),
      .i_uses_rs    (bus.in_uses_rs),
      .i_uses_rt    (bus.in_uses_rt),
      .o_hazard     (w_hazard)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_rs      <= '0;
         r_rt      <= '0;
         r_rd      <= '0;
         r_dst     <= '0;
         r_uses_rs <= 1'b0;
         r_uses_rt <= 1'b0;
         r_is_load <= 1'b0;
         r_ctrl    <= '0;
         r_imm     <= '0;
         r_pc_next <= '0;
         r_shamt   <= '0;
      end else if (w_adv) begin
         r_valid   <= w_take;
         r_rs      <= w_take ? bus.in_rs      : '0;
         r_rt      <= w_take ? bus.in_rt      : '0;
         r_rd      <= w_take ? bus.in_rd      : '0;
         r_dst     <= w_take ? bus.in_dst     : '0;
         r_uses_rs <= w_take & bus.in_uses_rs;
         r_uses_rt <= w_take & bus.in_uses_rt;
         r_is_load <= w_take & bus.in_is_load;
         r_ctrl    <= w_take ? bus.in_ctrl    : '0;
         r_imm     <= w_take ? bus.in_imm     : '0;
         r_pc_next <= w_take ? bus.in_pc_next : '0;
         r_shamt   <= w_take ? bus.in_shamt   : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (w_bump)
         r_cnt <= r_cnt + 1'b1;
   end

   assign bus.out_valid   = r_valid;
   assign bus.out_rs      = r_rs;
   assign bus.out_rt      = r_rt;
   assign bus.out_rd      = r_rd;
   assign bus.out_dst     = r_dst;
   assign bus.out_uses_rs = r_uses_rs;
   assign bus.out_uses_rt = r_uses_rt;
   assign bus.out_is_load = r_is_load;
   assign bus.out_ctrl    = r_ctrl;
   assign bus.out_imm     = r_imm;
   assign bus.out_pc_next = r_pc_next;
   assign bus.out_shamt   = r_shamt;
   assign bus.bubble_cnt  = r_cnt;
   assign bus.stall_req   = rst_n & (w_hazard | bus.ext_stall);

endmodule

// File: tb/tb_decode_issue_reg.sv
// Bench for decode_issue_reg: directed load-use cases plus random traffic
// checked against a slot-history reference model.
module tb_decode_issue_reg;
   import pipe_pkg::*;

   localparam int LS = 2;
   localparam int PW = 4;
   localparam int DW = 32;
   localparam int AW = REG_AW_DEF;
   localparam int CW = CTRL_BITS;
   localparam int CNT_MAX = (1 << PW) - 1;

   typedef struct packed {
      logic          valid;
      reg_addr_t     rs, rt, rd;
      logic          uses_rs, uses_rt;
      reg_addr_t     dst;
      logic          is_load;
      logic [CW-1:0] ctrl;
      logic [DW-1:0] imm, pc;
      logic [4:0]    shamt;
   } insn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   decode_issue_reg_if #(
      .DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .PERF_W(PW)
   ) bus ();

   decode_issue_reg #(
      .DATA_W(DW), .REG_AW(AW), .CTRL_W(CW),
      .LOAD_STALL(LS), .PERF_W(PW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   insn_t m_out;
   int    hist[$];
   int    m_cnt;

   task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic insn_t mk(bit v, int rs, int rt, int dst, bit ld,
                                bit urs = 1, bit urt = 1);
      insn_t x;
      x.valid   = v;
      x.rs      = reg_addr_t'(rs);
      x.rt      = reg_addr_t'(rt);
      x.rd      = reg_addr_t'(dst);
      x.dst     = reg_addr_t'(dst);
      x.uses_rs = urs;
      x.uses_rt = urt;
      x.is_load = ld;
      x.ctrl    = CW'($urandom);
      x.imm     = $urandom;
      x.pc      = $urandom;
      x.shamt   = 5'($urandom);
      return x;
   endfunction

   function automatic insn_t dut_out();
      insn_t x;
      x.valid   = bus.out_valid;
      x.rs      = bus.out_rs;
      x.rt      = bus.out_rt;
      x.rd      = bus.out_rd;
      x.uses_rs = bus.out_uses_rs;
      x.uses_rt = bus.out_uses_rt;
      x.dst     = bus.out_dst;
      x.is_load = bus.out_is_load;
      x.ctrl    = bus.out_ctrl;
      x.imm     = bus.out_imm;
      x.pc      = bus.out_pc_next;
      x.shamt   = bus.out_shamt;
      return x;
   endfunction

   task automatic apply(insn_t x, bit fl, bit es);
      bus.in_valid   = x.valid;
      bus.in_rs      = x.rs;
      bus.in_rt      = x.rt;
      bus.in_rd      = x.rd;
      bus.in_dst     = x.dst;
      bus.in_uses_rs = x.uses_rs;
      bus.in_uses_rt = x.uses_rt;
      bus.in_is_load = x.is_load;
      bus.in_ctrl    = x.ctrl;
      bus.in_imm     = x.imm;
      bus.in_pc_next = x.pc;
      bus.in_shamt   = x.shamt;
      bus.flush      = fl;
      bus.ext_stall  = es;
   endtask

   // history of the last LS issue slots: load destination or 0
   function automatic void model_reset();
      m_out = '0;
      m_cnt = 0;
      hist  = {};
      for (int k = 0; k < LS; k++) hist.push_back(0);
   endfunction

   function automatic bit model_hazard(insn_t x);
      if (!x.valid) return 0;
      foreach (hist[k]) begin
         if (hist[k] != 0 &&
             ((x.uses_rs && int'(x.rs) == hist[k]) ||
              (x.uses_rt && int'(x.rt) == hist[k])))
            return 1;
      end
      return 0;
   endfunction

   function automatic void model_slot(int d);
      hist.push_front(d);
      void'(hist.pop_back());
   endfunction

   function automatic void model_edge(insn_t x, bit fl, bit es, bit hz);
      if (fl) begin
         m_out = '0;
         model_slot(0);
      end else if (es) begin
      end else if (hz) begin
         m_out = '0;
         model_slot(0);
         if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
         m_out = x.valid ? x : '0;
         model_slot((x.valid && x.is_load) ? int'(x.dst) : 0);
      end
   endfunction

   task automatic step(insn_t x, bit fl, bit es, string tag, output bit st);
      bit hz;
      apply(x, fl, es);
      #1;
      hz = model_hazard(x);
      st = hz | es;
      check({tag, ".stall"}, bus.stall_req, st);
      @(posedge clk);
      model_edge(x, fl, es, hz);
      #1;
      check({tag, ".out"}, dut_out(), m_out);
      check({tag, ".cnt"}, bus.bubble_cnt, m_cnt);
   endtask

   task automatic issue(insn_t x, string tag);
      bit st;
      int n = 0;
      do begin
         step(x, 1'b0, 1'b0, tag, st);
         n++;
      end while (st && n < 10);
      check({tag, ".bound"}, st, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      insn_t lw8, dep, ind, cur;
      bit st, fl, es;

      apply('0, 1'b0, 1'b0);
      model_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst.out", dut_out(), 0);
      check("rst.cnt", bus.bubble_cnt, 0);
      check("rst.stall", bus.stall_req, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      lw8 = mk(1, 1, 0, 8, 1, 1, 0);
      dep = mk(1, 8, 1, 9, 0);
      ind = mk(1, 2, 3, 10, 0);

      issue(lw8, "d1.lw");
      issue(dep, "d1.dep");
      check("d1.bubbles", bus.bubble_cnt, 2);

      issue(lw8, "d2.lw");
      issue(ind, "d2.ind");
      issue(dep, "d2.dep");
      check("d2.bubbles", bus.bubble_cnt, 3);

      issue(lw8, "d3.lw");
      issue(ind, "d3.ind1");
      issue(ind, "d3.ind2");
      issue(dep, "d3.dep");
      check("d3.bubbles", bus.bubble_cnt, 3);

      issue(mk(1, 1, 0, 0, 1, 1, 0), "r0.lw");
      issue(mk(1, 0, 0, 11, 0), "r0.dep");
      issue(lw8, "urt.lw");
      issue(mk(1, 1, 8, 12, 0, 1, 0), "urt.dep");
      check("nostall.cnt", bus.bubble_cnt, 3);

      issue(lw8, "fh.lw");
      step(dep, 1'b1, 1'b0, "fh.both", st);
      check("fh.stall", st, 1);
      check("fh.valid", bus.out_valid, 0);
      check("fh.cnt", bus.bubble_cnt, 3);
      issue(dep, "fh.dep");
      check("fh.expire", bus.bubble_cnt, 4);

      issue(lw8, "es.lw");
      for (int i = 0; i < 3; i++) step(dep, 1'b0, 1'b1, "es.hold", st);
      check("es.frozen", bus.out_dst, 8);
      issue(dep, "es.dep");
      check("es.cnt", bus.bubble_cnt, 6);

      issue(lw8, "ar.lw");
      step(dep, 1'b0, 1'b0, "ar.bub", st);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("ar.out", dut_out(), 0);
      check("ar.cnt", bus.bubble_cnt, 0);
      check("ar.stall", bus.stall_req, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      issue(dep, "ar.dep");
      check("ar.valid", bus.out_valid, 1);
      check("ar.nobub", bus.bubble_cnt, 0);

      st = 1'b0;
      cur = '0;
      for (int i = 0; i < 500; i++) begin
         if (!st)
            cur = mk($urandom_range(0, 7) != 0,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 15) == 0);
         es = ($urandom_range(0, 5) == 0);
         step(cur, fl, es, "rnd", st);
         if (fl) st = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
